wait_duration: RTL and testbench

// - Testbench-side timer feeding the sequencer's wait-duration-done input (the WAIT_DURATION command).
// - Sequencer decodes WAIT_DURATION <n> <unit>, raises i_sel_wait_duration with i_args_valid,

---
 rtl/wait_duration_if.sv | 42 ++++
 rtl/wait_duration.sv | 140 ++++++++++++++
 tb/tb_wait_duration.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/wait_duration_if.sv
// Handshake bundle between the sequencer and the wait_duration timer.
// Carries o_elapsed_cycles only when WAIT_DURATION_ELAPSED_EN is defined.
`timescale 1ns/1ps

interface wait_duration_if #(
   parameter int DUR_WIDTH = 32
);
   logic                 i_sel_wait_duration;
   logic                 i_args_valid;
   logic [DUR_WIDTH-1:0] i_duration;
   logic [1:0]           i_unit;
   logic                 i_abort;
   logic                 o_busy;
   logic                 o_wait_duration_done;
   logic                 o_err;
`ifdef WAIT_DURATION_ELAPSED_EN
   logic [31:0]          o_elapsed_cycles;
`endif

`ifdef WAIT_DURATION_ELAPSED_EN
   modport master (
      output i_sel_wait_duration, i_args_valid, i_duration, i_unit, i_abort,
      input  o_busy, o_wait_duration_done, o_err, o_elapsed_cycles
   );

   modport slave (
      input  i_sel_wait_duration, i_args_valid, i_duration, i_unit, i_abort,
      output o_busy, o_wait_duration_done, o_err, o_elapsed_cycles
   );
`else
   modport master (
      output i_sel_wait_duration, i_args_valid, i_duration, i_unit, i_abort,
      input  o_busy, o_wait_duration_done, o_err
   );

   modport slave (
      input  i_sel_wait_duration, i_args_valid, i_duration, i_unit, i_abort,
      output o_busy, o_wait_duration_done, o_err
   );
`endif

endinterface : wait_duration_if

// File: rtl/wait_duration.sv
// Picosecond-resolution wait timer answering the sequencer's WAIT_DURATION command.
// Define WAIT_DURATION_ELAPSED_EN to add the o_elapsed_cycles run-length counter.
`timescale 1ns/1ps

module wait_duration #(
   parameter int CLK_PERIOD = 20000,
   parameter int DUR_WIDTH  = 32,
   parameter int TIME_WIDTH = 64
) (
   input  logic            clk,
   input  logic            rst,
   wait_duration_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   localparam logic [TIME_WIDTH-1:0] PERIOD_PS = TIME_WIDTH'(CLK_PERIOD);
   localparam logic [TIME_WIDTH-1:0] NS_PS     = TIME_WIDTH'(1000);
   localparam logic [TIME_WIDTH-1:0] US_PS     = TIME_WIDTH'(1_000_000);
   localparam logic [TIME_WIDTH-1:0] MS_PS     = TIME_WIDTH'(1_000_000_000);

   state_e                state_q,   state_d;
   logic [TIME_WIDTH-1:0] target_q,  target_d;
   logic [TIME_WIDTH-1:0] elapsed_q, elapsed_d;
   logic                  busy_q,    busy_d;
   logic                  done_q,    done_d;
   logic                  err_q,     err_d;

   logic                  start;
   logic                  accept;
   logic [TIME_WIDTH-1:0] duration_w;
   logic [TIME_WIDTH-1:0] target_start;
   logic [TIME_WIDTH-1:0] elapsed_inc;

   // Target in picoseconds for the command currently on the inputs.
   always_comb begin
      duration_w   = TIME_WIDTH'(bus.i_duration);
      target_start = '0;
      case (bus.i_unit)
         2'd0:    target_start = duration_w * PERIOD_PS;
         2'd1:    target_start = duration_w * NS_PS;
         2'd2:    target_start = duration_w * US_PS;
         2'd3:    target_start = duration_w * MS_PS;
         default: target_start = '0;
      endcase
   end

   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
      state_d     = state_q;
      target_d    = target_q;
      elapsed_d   = elapsed_q;
      err_d       = 1'b0;
      start       = bus.i_sel_wait_duration & bus.i_args_valid;
      accept      = 1'b0;
      elapsed_inc = elapsed_q + PERIOD_PS;

      case (state_q)
         S_IDLE, S_DONE: begin
            // Abort on the same edge drops the start, even outside RUN.
            if (start && !bus.i_abort) begin
               accept    = 1'b1;
               state_d   = S_RUN;
               target_d  = target_start;
               elapsed_d = '0;
            end else begin
               state_d   = S_IDLE;
            end
         end
         S_RUN: begin
            if (bus.i_abort) begin
               state_d = S_IDLE;
            end else begin
               elapsed_d = elapsed_inc;
               err_d     = start;
               if (elapsed_inc >= target_q) begin
                  state_d = S_DONE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d == S_RUN);
      done_d = (state_d == S_DONE);
   end

`ifdef WAIT_DURATION_ELAPSED_EN
   logic [31:0] elapsed_cycles_q, elapsed_cycles_d;

   always_comb begin
      elapsed_cycles_d = elapsed_cycles_q;
      if (accept) begin
         elapsed_cycles_d = '0;
      end else if (state_q == S_RUN && elapsed_cycles_q != '1) begin
         elapsed_cycles_d = elapsed_cycles_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         elapsed_cycles_q <= '0;
      end else begin
         elapsed_cycles_q <= elapsed_cycles_d;
      end
   end

   assign bus.o_elapsed_cycles = elapsed_cycles_q;
`endif

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
      if (rst) begin
         state_q   <= S_IDLE;
         target_q  <= '0;
         elapsed_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         target_q  <= target_d;
         elapsed_q <= elapsed_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign bus.o_busy               = busy_q;
   assign bus.o_wait_duration_done = done_q;
   assign bus.o_err                = err_q;

endmodule : wait_duration

// File: tb/tb_wait_duration.sv
// Directed self-checking bench for wait_duration (CLK_PERIOD = 20000 ps, 20 ns clock).
// Covers the elapsed-cycle counter too when WAIT_DURATION_ELAPSED_EN is defined.
`timescale 1ns/1ps

module tb_wait_duration;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_bad = 0;

   wait_duration_if #(.DUR_WIDTH(32)) bus ();

   wait_duration #(
      .CLK_PERIOD (20000),
      .DUR_WIDTH  (32),
      .TIME_WIDTH (64)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance to 1 ns after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_start(input logic on, input logic [31:0] n, input logic [1:0] u);
      bus.i_sel_wait_duration = on;
      bus.i_args_valid        = on;
      bus.i_duration          = n;
      bus.i_unit              = u;
   endtask

   // Issue one start; returns just after the accept edge.
   task automatic start_cmd(input logic [31:0] n, input logic [1:0] u);
      set_start(1'b1, n, u);
      tick();
      set_start(1'b0, 32'd0, 2'd0);
   endtask

   // Cycles after entry until done is seen (-1 on timeout), busy samples before done, err pulses.
   task automatic wait_done(input int max, output int cycles, output int busy_cnt, output int err_cnt);
      cycles   = -1;
      busy_cnt = 0;
      err_cnt  = 0;
      for (int k = 1; k <= max; k++) begin
         if (bus.o_busy) busy_cnt++;
         tick();
         if (bus.o_err) err_cnt++;
         if (bus.o_wait_duration_done) begin
            cycles = k;
            break;
         end
      end
   endtask

   task automatic count_done(input int ncyc, output int dcnt);
      dcnt = 0;
      for (int k = 0; k < ncyc; k++) begin
         tick();
         if (bus.o_wait_duration_done) dcnt++;
      end
   endtask

   initial begin
      int c, b, e, d;

      rst = 1'b1;
      set_start(1'b0, 32'd0, 2'd0);
      bus.i_abort = 1'b0;
      tick();
      tick();
      check("rst_busy", 64'(bus.o_busy), 64'd0);
      check("rst_done", 64'(bus.o_wait_duration_done), 64'd0);
      check("rst_err",  64'(bus.o_err), 64'd0);
`ifdef WAIT_DURATION_ELAPSED_EN
      check("rst_elapsed", 64'(bus.o_elapsed_cycles), 64'd0);
`endif
      rst = 1'b0;
      tick();

      // Select without args-valid is not a start.
      bus.i_sel_wait_duration = 1'b1;
      bus.i_duration          = 32'd5;
      tick();
      bus.i_sel_wait_duration = 1'b0;
      tick();
      check("sel_no_valid_busy", 64'(bus.o_busy), 64'd0);

      // 10 clock cycles.
      start_cmd(32'd10, 2'd0);
      check("n10_busy_after_accept", 64'(bus.o_busy), 64'd1);
      wait_done(400, c, b, e);
      check("n10_latency",    64'(c), 64'd10);
      check("n10_busy_cycles", 64'(b), 64'd10);
      check("n10_busy_in_done", 64'(bus.o_busy), 64'd0);
      tick();
      check("n10_done_width", 64'(bus.o_wait_duration_done), 64'd0);

      // 30 ns -> ceil(30000/20000) = 2.
      start_cmd(32'd30, 2'd1);
      wait_done(400, c, b, e);
      check("n30ns_latency", 64'(c), 64'd2);
      tick();

      // 5 us -> 5e6/2e4 = 250.
      start_cmd(32'd5, 2'd2);
      wait_done(400, c, b, e);
      check("n5us_latency", 64'(c), 64'd250);
      tick();

      // Zero duration still takes one cycle.
      start_cmd(32'd0, 2'd3);
      wait_done(400, c, b, e);
      check("n0_latency", 64'(c), 64'd1);
      check("n0_no_err",  64'(e), 64'd0);
      tick();

      // Second start at cycle 20 of a 100-cycle wait.
      start_cmd(32'd100, 2'd0);
      repeat (19) tick();
      set_start(1'b1, 32'd3, 2'd0);
      tick();
      set_start(1'b0, 32'd0, 2'd0);
      check("busy_start_err", 64'(bus.o_err), 64'd1);
      tick();
      check("busy_start_err_width", 64'(bus.o_err), 64'd0);
      wait_done(400, c, b, e);
      check("n100_remaining_latency", 64'(c), 64'd79);
      check("n100_no_extra_err", 64'(e), 64'd0);
      tick();

      // Abort at cycle 10 of a 50-cycle wait.
      start_cmd(32'd50, 2'd0);
      repeat (10) tick();
      bus.i_abort = 1'b1;
      tick();
      bus.i_abort = 1'b0;
      check("abort_busy", 64'(bus.o_busy), 64'd0);
      check("abort_done", 64'(bus.o_wait_duration_done), 64'd0);
      count_done(60, d);
      check("abort_no_done", 64'(d), 64'd0);
      start_cmd(32'd3, 2'd0);
      wait_done(400, c, b, e);
      check("after_abort_latency", 64'(c), 64'd3);
      tick();

      // Abort and start on the same edge in RUN: abort wins, no err.
      start_cmd(32'd20, 2'd0);
      repeat (5) tick();
      bus.i_abort = 1'b1;
      set_start(1'b1, 32'd4, 2'd0);
      tick();
      bus.i_abort = 1'b0;
      set_start(1'b0, 32'd0, 2'd0);
      check("abort_start_err",  64'(bus.o_err), 64'd0);
      check("abort_start_busy", 64'(bus.o_busy), 64'd0);
      tick();
      check("abort_start_dropped", 64'(bus.o_busy), 64'd0);

      // Abort with start in IDLE drops the start.
      bus.i_abort = 1'b1;
      set_start(1'b1, 32'd4, 2'd0);
      tick();
      bus.i_abort = 1'b0;
      set_start(1'b0, 32'd0, 2'd0);
      check("idle_abort_start_busy", 64'(bus.o_busy), 64'd0);
      tick();

      // Back-to-back: new start presented during the DONE cycle.
      start_cmd(32'd4, 2'd0);
      wait_done(400, c, b, e);
      check("b2b_first_latency", 64'(c), 64'd4);
      set_start(1'b1, 32'd4, 2'd0);
      tick();
      set_start(1'b0, 32'd0, 2'd0);
      check("b2b_busy",    64'(bus.o_busy), 64'd1);
      check("b2b_no_done", 64'(bus.o_wait_duration_done), 64'd0);
      wait_done(400, c, b, e);
      check("b2b_second_latency", 64'(c), 64'd4);
      tick();

      // Reset in the middle of a wait.
      start_cmd(32'd50, 2'd0);
      repeat (5) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_busy", 64'(bus.o_busy), 64'd0);
      check("midrst_done", 64'(bus.o_wait_duration_done), 64'd0);
      check("midrst_err",  64'(bus.o_err), 64'd0);
`ifdef WAIT_DURATION_ELAPSED_EN
      check("midrst_elapsed", 64'(bus.o_elapsed_cycles), 64'd0);
`endif
      count_done(80, d);
      check("midrst_no_done", 64'(d), 64'd0);

`ifdef WAIT_DURATION_ELAPSED_EN
      start_cmd(32'd7, 2'd0);
      wait_done(400, c, b, e);
      check("n7_latency", 64'(c), 64'd7);
      check("n7_elapsed", 64'(bus.o_elapsed_cycles), 64'd7);
      repeat (3) tick();
      check("n7_elapsed_hold", 64'(bus.o_elapsed_cycles), 64'd7);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_wait_duration
